pwm_measure_axil_slave: RTL and testbench

AXI4-Lite responder (slave) exposing a PWM measurement engine to the processing system. It terminates the AXI4-Lite transactions issued by the system master and answers them with register data. It samples one external PWM input and reports high time and period in clock cycles. It sits between the AXI interconnect and the PWM receiver pins of the UGV motor/servo path.

---
 rtl/pwm_measure_pkg.sv | 41 ++++
 rtl/pwm_edge_timer.sv | 92 +++++++++
 rtl/pwm_measure_axil_slave.sv | 166 ++++++++++++++++
 tb/tb_pwm_measure_axil_slave.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_measure_pkg.sv
// Shared constants and FSM state types for the PWM measurement AXI4-Lite slave.
package pwm_measure_pkg;

    localparam logic [3:0] RegCtrlOffset     = 4'h0;
    localparam logic [3:0] RegTimeoutOffset  = 4'h4;
    localparam logic [3:0] RegHighTimeOffset = 4'h8;
    localparam logic [3:0] RegPeriodOffset   = 4'hC;

    localparam int unsigned CtrlEnBit    = 0;
    localparam int unsigned CtrlInvBit   = 1;
    localparam int unsigned CtrlIrqEnBit = 2;

    localparam logic [1:0] RespOkay = 2'b00;

    typedef enum logic [1:0] {
        WIdle,
        WAck,
        WResp
    } w_state_e;

    typedef enum logic [1:0] {
        RIdle,
        RAck,
        RData
    } r_state_e;

    // Merge a bus write into an existing register, byte lane by byte lane.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_edge_timer.sv
// PWM edge timer: input synchronizer, edge detection, saturating counter and timeout.
module pwm_edge_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        inv_i,
    input  logic [31:0] timeout_i,
    input  logic        pwm_i,
    output logic [31:0] high_time_o,
    output logic [31:0] period_o,
    output logic        new_period_o,
    output logic        timeout_o
);

    logic [1:0]  sync_q, sync_d;
    logic        lvl_q, lvl_d;
    logic        prev_q, prev_d;
    logic        armed_q, armed_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] high_time_q, high_time_d;
    logic [31:0] period_q, period_d;

    logic rise, fall, tmo_hit;

    always_comb begin
        sync_d       = {sync_q[0], pwm_i};
        lvl_d        = sync_q[1] ^ inv_i;
        prev_d       = prev_q;
        armed_d      = armed_q;
        cnt_d        = cnt_q;
        high_time_d  = high_time_q;
        period_d     = period_q;
        new_period_o = 1'b0;
        timeout_o    = 1'b0;

        rise    = en_i & lvl_q & ~prev_q;
        fall    = en_i & ~lvl_q & prev_q;
        tmo_hit = en_i && (timeout_i != 32'd0) && (cnt_q == timeout_i);

        if (!en_i) begin
            prev_d  = 1'b0;
            cnt_d   = 32'd0;
            armed_d = 1'b0;
        end else begin
            prev_d = lvl_q;
            cnt_d  = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

            if (fall && armed_q) begin
                high_time_d = cnt_q;
            end

            // A rising edge in the same cycle as a timeout takes precedence.
            if (rise) begin
                cnt_d   = 32'd1;
                armed_d = 1'b1;
                if (armed_q) begin
                    period_d     = cnt_q;
                    new_period_o = 1'b1;
                end
            end else if (tmo_hit) begin
                high_time_d = 32'd0;
                period_d    = 32'd0;
                armed_d     = 1'b0;
                timeout_o   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q      <= 2'b00;
            lvl_q       <= 1'b0;
            prev_q      <= 1'b0;
            armed_q     <= 1'b0;
            cnt_q       <= 32'd0;
            high_time_q <= 32'd0;
            period_q    <= 32'd0;
        end else begin
            sync_q      <= sync_d;
            lvl_q       <= lvl_d;
            prev_q      <= prev_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            high_time_q <= high_time_d;
            period_q    <= period_d;
        end
    end

    assign high_time_o = high_time_q;
    assign period_o    = period_q;

endmodule

// File: rtl/pwm_measure_axil_slave.sv
// AXI4-Lite register front end for the PWM edge timer.
// Optional interrupt output enabled by defining PWM_MEAS_IRQ_EN.
module pwm_measure_axil_slave
    import pwm_measure_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            pwm_in
`ifdef PWM_MEAS_IRQ_EN
    ,
    output logic                            irq
`endif
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic [DW-1:0] ctrl_q, ctrl_d;
    logic [DW-1:0] timeout_q, timeout_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [31:0] high_time, period;
    logic        new_period, tmo_pulse;

    logic       wr_en, rd_cap;
    logic [3:0] wr_off, rd_off;

    assign wr_en  = (w_state_q == WAck);
    assign rd_cap = (r_state_q == RAck);
    assign wr_off = {S_AXI_AWADDR[3:2], 2'b00};
    assign rd_off = {S_AXI_ARADDR[3:2], 2'b00};

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            WIdle:   if (S_AXI_AWVALID && S_AXI_WVALID) w_state_d = WAck;
            WAck:    w_state_d = WResp;
            WResp:   if (S_AXI_BREADY) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            RIdle:   if (S_AXI_ARVALID) r_state_d = RAck;
            RAck:    r_state_d = RData;
            RData:   if (S_AXI_RREADY) r_state_d = RIdle;
            default: r_state_d = RIdle;
        endcase
    end

    // Read-only offsets simply fall through, dropping the write.
    always_comb begin
        ctrl_d    = ctrl_q;
        timeout_d = timeout_q;
        if (wr_en) begin
            case (wr_off)
                RegCtrlOffset:    ctrl_d    = apply_wstrb(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB);
                RegTimeoutOffset: timeout_d = apply_wstrb(timeout_q, S_AXI_WDATA, S_AXI_WSTRB);
                default:          ;
            endcase
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_cap) begin
            case (rd_off)
                RegCtrlOffset:     rdata_d = ctrl_q;
                RegTimeoutOffset:  rdata_d = timeout_q;
                RegHighTimeOffset: rdata_d = high_time;
                RegPeriodOffset:   rdata_d = period;
                default:           rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= WIdle;
            r_state_q <= RIdle;
            ctrl_q    <= '0;
            timeout_q <= '0;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            ctrl_q    <= ctrl_d;
            timeout_q <= timeout_d;
            rdata_q   <= rdata_d;
        end
    end

    pwm_edge_timer u_edge_timer (
        .clk_i        (ACLK),
        .rst_i        (ARESET),
        .en_i         (ctrl_q[CtrlEnBit]),
        .inv_i        (ctrl_q[CtrlInvBit]),
        .timeout_i    (timeout_q),
        .pwm_i        (pwm_in),
        .high_time_o  (high_time),
        .period_o     (period),
        .new_period_o (new_period),
        .timeout_o    (tmo_pulse)
    );

`ifdef PWM_MEAS_IRQ_EN
    logic irq_q, irq_d;

    // A new event in the same cycle as the clearing read keeps the flag set.
    always_comb begin
        irq_d = irq_q;
        if (rd_cap && (rd_off == RegPeriodOffset)) irq_d = 1'b0;
        if (new_period || tmo_pulse) irq_d = 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign irq = irq_q & ctrl_q[CtrlIrqEnBit];

    logic unused_sig;
    assign unused_sig = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};
`else
    logic unused_sig;
    assign unused_sig = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                          new_period, tmo_pulse};
`endif

    assign S_AXI_AWREADY = wr_en;
    assign S_AXI_WREADY  = wr_en;
    assign S_AXI_BVALID  = (w_state_q == WResp);
    assign S_AXI_BRESP   = RespOkay;
    assign S_AXI_ARREADY = rd_cap;
    assign S_AXI_RVALID  = (r_state_q == RData);
    assign S_AXI_RRESP   = RespOkay;
    assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_pwm_measure_axil_slave.sv
// Scoreboard bench for pwm_measure_axil_slave: bus register access, PWM measurement, stall/reset.
module tb_pwm_measure_axil_slave;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        pwm_in;
`ifdef PWM_MEAS_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    pwm_measure_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .ACLK          (clk),
        .ARESET        (areset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .pwm_in        (pwm_in)
`ifdef PWM_MEAS_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd_exp_q[$];
    string       rd_tag_q[$];
    logic [1:0]  b_exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        b_exp_q.push_back(2'b00);
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("aw_latency", n, 1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("b_latency", n, 0);
        check_eq("bresp", {30'b0, bresp}, {30'b0, b_exp_q.pop_front()});
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        int n;
        rd_exp_q.push_back(exp);
        rd_tag_q.push_back(tag);
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("ar_latency", n, 1);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("rvalid", {31'b0, rvalid}, 1);
        check_eq(rd_tag_q.pop_front(), rdata, rd_exp_q.pop_front());
        check_eq("rresp", {30'b0, rresp}, 0);
    endtask

    // PWM source: 300 cycles high, 700 low while pwm_run is set.
    logic pwm_run  = 1'b0;
    logic pwm_idle = 1'b1;
    initial begin
        pwm_in = 1'b0;
        forever begin
            @(negedge clk);
            if (pwm_run) begin
                pwm_idle = 1'b0;
                pwm_in   = 1'b1;
                repeat (300) @(negedge clk);
                pwm_in = 1'b0;
                repeat (699) @(negedge clk);
            end else begin
                pwm_idle = 1'b1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        areset = 1'b1;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; arvalid = 0; wdata = '0; wstrb = '0;
        bready = 1'b1; rready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_handshake", {27'b0, awready, wready, bvalid, arready, rvalid}, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_resp", {28'b0, bresp, rresp}, 0);
        areset = 1'b0;

        // Read-only registers ignore writes.
        axi_write(4'h8, 32'hDEAD_0011, 4'hF);
        axi_read(4'h8, 32'h0, "high_time_ro");
        axi_read(4'hC, 32'h0, "period_rst");

        axi_write(4'h0, 32'h0101_FFFF, 4'hF);
        axi_write(4'h4, 32'hABCD_0001, 4'hF);
        axi_read(4'h0, 32'h0101_FFFF, "ctrl_rb");
        axi_read(4'h4, 32'hABCD_0001, "timeout_rb");

        // Read captured alongside a write to the same register sees the old value.
        fork
            axi_write(4'h4, 32'h0000_0000, 4'hF);
            axi_read(4'h4, 32'hABCD_0001, "rd_during_wr");
        join
        axi_read(4'h4, 32'h0, "timeout_after");

        axi_write(4'h0, 32'h0000_0000, 4'hF);
        axi_write(4'h0, 32'h1234_5678, 4'b0110);
        axi_read(4'h0, 32'h0034_5600, "ctrl_wstrb");
        axi_write(4'h0, 32'h0000_0000, 4'hF);

        // Normal polarity measurement.
        axi_write(4'h0, 32'h1, 4'hF);
        pwm_run = 1'b1;
        repeat (2600) @(negedge clk);
        axi_read(4'h8, 32'd300, "high_time");
        axi_read(4'hC, 32'd1000, "period");

        // Inverted polarity.
        axi_write(4'h0, 32'h3, 4'hF);
        repeat (2600) @(negedge clk);
        axi_read(4'h8, 32'd700, "high_time_inv");
        axi_read(4'hC, 32'd1000, "period_inv");

        // Timeout with interrupt enabled.
        axi_write(4'h0, 32'h5, 4'hF);
        repeat (2600) @(negedge clk);
        axi_write(4'h4, 32'd5000, 4'hF);
        pwm_run = 1'b0;
        n = 0;
        while (!pwm_idle && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("pwm_idle", {31'b0, pwm_idle}, 1);
        repeat (1500) @(negedge clk);
        axi_read(4'h8, 32'd300, "high_time_pre_tmo");
        axi_read(4'hC, 32'd1000, "period_pre_tmo");
`ifdef PWM_MEAS_IRQ_EN
        check_eq("irq_cleared", {31'b0, irq}, 0);
`endif
        repeat (4000) @(negedge clk);
        axi_read(4'h8, 32'd0, "high_time_tmo");
`ifdef PWM_MEAS_IRQ_EN
        check_eq("irq_tmo", {31'b0, irq}, 1);
`endif
        axi_read(4'hC, 32'd0, "period_tmo");
`ifdef PWM_MEAS_IRQ_EN
        check_eq("irq_after_read", {31'b0, irq}, 0);
`endif

        // Stalled responses, then reset mid-transaction.
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        awaddr = 4'h0; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; araddr = 4'h4;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        repeat (2) @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("bvalid_stall", {31'b0, bvalid}, 1);
        check_eq("rvalid_stall", {31'b0, rvalid}, 1);
        check_eq("rdata_stall", rdata, 32'd5000);
        areset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_handshake", {27'b0, awready, wready, bvalid, arready, rvalid}, 0);
`ifdef PWM_MEAS_IRQ_EN
        check_eq("post_rst_irq", {31'b0, irq}, 0);
`endif
        areset = 1'b0;
        bready = 1'b1; rready = 1'b1;
        axi_read(4'h0, 32'h0, "ctrl_post_rst");
        axi_read(4'h4, 32'h0, "timeout_post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
